ewb_mem_arbiter: RTL and testbench
==================================

// Module: ewb_mem_arbiter
// PURPOSE
// Sequences the L2 eviction write buffer (EWB) and shares the single physical-memory port
// between L2 read misses and EWB drains. Keeps a shadow copy of the line addresses queued
// in the EWB and uses it to block reads that would bypass a pending writeback (RAW hazard).
// Sits between the L2 cache, its EWB FIFO and the pmem interface.
// PARAMETERS
// WIDTH   256  cache line width in bits; also the EWB data width
// INDEX   2    log2 of EWB depth; must equal the EWB INDEX (depth 4)
// OFFSET  5    line-offset bits; line address = addr[31:OFFSET]
// PORTS
// clk            in   1      clock
// rst            in   1      synchronous, active-high reset
// l2_read        in   1      L2 read-miss request; held high until l2_resp
// l2_address     in   32     read address; stable while l2_read
// l2_rdata       out  WIDTH  read line; valid when l2_resp
// l2_resp        out  1      one-cycle read completion pulse
// evict_valid    in   1      L2 pushes an eviction into the EWB (EWB valid_i)
// evict_ready    in   1      EWB ready_o; a push occurs when evict_valid & evict_ready
// evict_address  in   32     line address of the pushed eviction
// ewb_valid      in   1      EWB valid_o (head entry present)
// ewb_data       in   WIDTH  EWB head line (data_o)
// ewb_yumi       out  1      EWB yumi_i: pops the head entry
// pmem_read      out  1      memory read request
// pmem_write     out  1      memory write request
// pmem_address   out  32     memory address, offset bits forced to 0
// pmem_wdata     out  WIDTH  memory write data (= ewb_data in WRITE)
// pmem_rdata     in   WIDTH  memory read data
// pmem_resp      in   1      one-cycle memory completion pulse
// BEHAVIOUR
// - Reset: state IDLE; shadow cleared (count 0); all outputs 0.
// - Shadow queue: 2**INDEX line addresses plus INDEX+1-bit wrapping read and write pointers.
//   Push on evict_valid&evict_ready; pop on ewb_yumi. Both may occur in one cycle.
//   Shadow empty/full must track the EWB exactly: ewb_valid == (count != 0).
// - hazard = l2_read & (l2_address[31:OFFSET] matches any occupied shadow entry, or the
//   entry being pushed this cycle).
// - FSM states {IDLE, READ, WRITE}. A transaction is non-preemptive once started.
//   IDLE decides in priority order:
//   (1) evict_valid & ~evict_ready & ewb_valid -> WRITE (unblock a stalled eviction);
//   (2) l2_read & ~hazard -> READ;
//   (3) ewb_valid -> WRITE (drain, including on hazard);
//   (4) otherwise stay in IDLE.
// - Requests are registered: pmem_read or pmem_write rises the cycle after the IDLE
//   decision. pmem_address and pmem_wdata are held constant until pmem_resp.
//   READ address = {l2_address[31:OFFSET], 0}. WRITE address = {shadow head, 0}.
// - READ: on pmem_resp, l2_resp=1 and l2_rdata=pmem_rdata in the same cycle
//   (combinational pass). Then pmem_read=0 and the FSM returns to IDLE.
// - WRITE: on pmem_resp, ewb_yumi=1 for exactly that cycle. Then pmem_write=0 and
//   the FSM returns to IDLE.
// - pmem_read and pmem_write are never both high. ewb_yumi is never high while ewb_valid=0.
// - Minimum turnaround: one IDLE cycle between transactions.
// - A hazarded read waits through successive drains until no shadow entry matches, then issues.
// - Reset mid-transaction aborts it: outputs drop the next cycle, the shadow is cleared,
//   and the EWB resets on the same rst. pmem_resp arriving in IDLE is ignored.
// STRUCTURE
// - Package rv32i_types: enum ewb_arb_state_t {IDLE, READ, WRITE}; localparam line-address width.
// - Sub-module ewb_addr_tracker: the shadow address ring, with push/pop, head address,
//   count and a match vector. The arbiter FSM and pmem muxing stay in this module.
// TESTING
// - Read only: EWB empty, l2_read @0x0000_1040, pmem_resp after 5 cycles
//   -> pmem_read @0x0000_1040 held until resp; l2_resp 1 cycle; no writes.
// - Drain: push 2 evictions @0x100, 0x200, no reads -> two writes in order 0x100 then 0x200,
//   ewb_yumi pulses on each resp; shadow count ends at 0.
// - Read priority: 1 eviction @0x300 queued plus l2_read @0x400 in the same IDLE
//   -> read 0x400 first, then write 0x300.
// - RAW hazard: evictions @0x500, 0x520 queued, l2_read @0x520 -> writes 0x500 then 0x520,
//   then read 0x520; the read never precedes the write.
// - Full stall: fill EWB (4 entries), evict_valid held with ready=0, l2_read pending
//   -> one write first, the push completes, then the read.
// - Reset mid-WRITE: assert rst during WRITE -> next cycle pmem_write=0, ewb_yumi=0,
//   count=0; a late pmem_resp causes no pop.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and sizing for the L2 eviction-write-buffer memory arbiter.
package rv32i_types;

  localparam int unsigned EWB_WIDTH  = 256;
  localparam int unsigned EWB_INDEX  = 2;
  localparam int unsigned EWB_OFFSET = 5;
  localparam int unsigned EWB_LINE_W = 32 - EWB_OFFSET;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } ewb_arb_state_t;

  // Registered physical-memory request (command + line-aligned address).
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
  } pmem_req_t;

endpackage

// File: rtl/ewb_addr_tracker.sv
// Shadow ring of line addresses queued in the EWB; flags entries matching a query.
module ewb_addr_tracker
  import rv32i_types::*;
#(
  parameter int unsigned INDEX  = EWB_INDEX,
  parameter int unsigned LINE_W = EWB_LINE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [LINE_W-1:0]     push_addr,
  input  logic                  pop,
  input  logic [LINE_W-1:0]     query_addr,
  output logic [LINE_W-1:0]     head_addr,
  output logic [INDEX:0]        count,
  output logic [(2**INDEX)-1:0] match
);

  localparam int unsigned DEPTH = 2 ** INDEX;

  logic [INDEX:0]      wr_ptr;
  logic [INDEX:0]      rd_ptr;
  logic [LINE_W-1:0]   ring [DEPTH];
  logic [INDEX-1:0]    rel  [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (INDEX+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (INDEX+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) ring[wr_ptr[INDEX-1:0]] <= push_addr;
  end

  assign head_addr = ring[rd_ptr[INDEX-1:0]];
  assign count     = wr_ptr - rd_ptr;

  // A slot is occupied when its distance from the head is below the count.
  always_comb begin
    match = '0;
    rel   = '{default: '0};
    for (int i = 0; i < DEPTH; i++) begin
      rel[i] = INDEX'(i) - rd_ptr[INDEX-1:0];
      if (({1'b0, rel[i]} < count) && (ring[i] == query_addr)) match[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ewb_mem_arbiter.sv
// Shares the pmem port between L2 read misses and EWB drains, blocking reads that
// would overtake a queued writeback of the same line.
module ewb_mem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH  = EWB_WIDTH,
  parameter int unsigned INDEX  = EWB_INDEX,
  parameter int unsigned OFFSET = EWB_OFFSET
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             l2_read,
  input  logic [31:0]      l2_address,
  output logic [WIDTH-1:0] l2_rdata,
  output logic             l2_resp,
  input  logic             evict_valid,
  input  logic             evict_ready,
  input  logic [31:0]      evict_address,
  input  logic             ewb_valid,
  input  logic [WIDTH-1:0] ewb_data,
  output logic             ewb_yumi,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [31:0]      pmem_address,
  output logic [WIDTH-1:0] pmem_wdata,
  input  logic [WIDTH-1:0] pmem_rdata,
  input  logic             pmem_resp
);

  localparam int unsigned LINE_W = 32 - OFFSET;

  ewb_arb_state_t           state_q, state_d;
  pmem_req_t                req_q, req_d;
  logic [WIDTH-1:0]         wdata_q, wdata_d;

  logic                     push;
  logic [LINE_W-1:0]        rd_line;
  logic [LINE_W-1:0]        evict_line;
  logic [LINE_W-1:0]        head_line;
  logic [INDEX:0]           shadow_count;
  logic [(2**INDEX)-1:0]    match;
  logic                     hazard;
  logic                     stalled_evict;
  logic                     unused_bits;

  assign push       = evict_valid & evict_ready;
  assign rd_line    = l2_address[31:OFFSET];
  assign evict_line = evict_address[31:OFFSET];

  ewb_addr_tracker #(
    .INDEX  (INDEX),
    .LINE_W (LINE_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (evict_line),
    .pop        (ewb_yumi),
    .query_addr (rd_line),
    .head_addr  (head_line),
    .count      (shadow_count),
    .match      (match)
  );

  // The line being pushed this cycle counts as queued for hazard purposes.
  assign hazard        = l2_read & ((|match) | (push & (evict_line == rd_line)));
  assign stalled_evict = evict_valid & ~evict_ready & ewb_valid;

  // Completion strobes pass straight through in the pmem_resp cycle.
  assign l2_resp   = (state_q == READ) & pmem_resp;
  assign l2_rdata  = l2_resp ? pmem_rdata : '0;
  assign ewb_yumi  = (state_q == WRITE) & pmem_resp & ewb_valid;

  assign pmem_read    = req_q.read;
  assign pmem_write   = req_q.write;
  assign pmem_address = req_q.address;
  assign pmem_wdata   = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and registered request; transactions run to pmem_resp once started.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (l2_read && !hazard && !stalled_evict) begin
          state_d       = READ;
          req_d.read    = 1'b1;
          req_d.write   = 1'b0;
          req_d.address = {rd_line, {OFFSET{1'b0}}};
        end else if (ewb_valid) begin
          state_d       = WRITE;
          req_d.read    = 1'b0;
          req_d.write   = 1'b1;
          req_d.address = {head_line, {OFFSET{1'b0}}};
          wdata_d       = ewb_data;
        end
      end
      READ, WRITE: begin
        if (pmem_resp) begin
          state_d     = IDLE;
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign unused_bits = ^{l2_address[OFFSET-1:0], evict_address[OFFSET-1:0], shadow_count};

endmodule

// File: tb/tb_ewb_mem_arbiter.sv
// Directed bench for ewb_mem_arbiter with a small EWB FIFO and pmem model.
module tb_ewb_mem_arbiter;

  localparam int unsigned W = 256;

  logic          clk;
  logic          rst;
  logic          l2_read;
  logic [31:0]   l2_address;
  logic [W-1:0]  l2_rdata;
  logic          l2_resp;
  logic          evict_valid;
  logic          evict_ready;
  logic [31:0]   evict_address;
  logic          ewb_valid;
  logic [W-1:0]  ewb_data;
  logic          ewb_yumi;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [W-1:0]  pmem_wdata;
  logic [W-1:0]  pmem_rdata;
  logic          pmem_resp;

  ewb_mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .l2_read       (l2_read),
    .l2_address    (l2_address),
    .l2_rdata      (l2_rdata),
    .l2_resp       (l2_resp),
    .evict_valid   (evict_valid),
    .evict_ready   (evict_ready),
    .evict_address (evict_address),
    .ewb_valid     (ewb_valid),
    .ewb_data      (ewb_data),
    .ewb_yumi      (ewb_yumi),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [W-1:0] data;
  } txn_t;

  typedef struct {
    int              lat;
    int              n_ev;
    logic [0:3][31:0] ev;
    bit              rd_en;
    int              rd_dly;
    logic [31:0]     rd_addr;
    int              n_exp;
    logic [0:3]      exp_wr;
    logic [0:3][31:0] exp_addr;
  } vec_t;

  int           n_cmp;
  int           n_err;
  int           lat;
  int           mem_cnt;
  bit           req_prev;
  logic [31:0]  req_addr;
  logic [W-1:0] req_wdata;
  bit           l2_resp_seen;
  logic [31:0]  fifo_a[$];
  logic [31:0]  pend[$];
  txn_t         log_q[$];

  function automatic logic [W-1:0] ev_data(input logic [31:0] a);
    return {8{a}};
  endfunction

  function automatic logic [W-1:0] rd_data(input logic [31:0] a);
    return {8{~a ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_ewb();
    ewb_valid     = (fifo_a.size() != 0);
    ewb_data      = ewb_valid ? ev_data(fifo_a[0]) : '0;
    evict_ready   = (fifo_a.size() < 4);
    evict_valid   = (pend.size() != 0);
    evict_address = evict_valid ? pend[0] : 32'h0;
  endtask

  // One clock: sample/check on the falling edge, update models just after the rising edge.
  task automatic tick();
    bit do_push, do_pop, saw_l2, saw_rst;
    txn_t t;
    @(negedge clk);
    do_push = evict_valid & evict_ready;
    do_pop  = ewb_yumi;
    saw_l2  = l2_resp;
    saw_rst = rst;
    if (!saw_rst) begin
      chk("rd_wr_exclusive", W'(pmem_read & pmem_write), W'(0));
      chk("yumi_on_write_resp", W'(ewb_yumi), W'(pmem_resp & pmem_write));
      chk("l2_resp_on_read_resp", W'(l2_resp), W'(pmem_resp & pmem_read));
      chk("shadow_tracks_ewb", W'(dut.u_tracker.count != 0), W'(ewb_valid));
      if (pmem_read || pmem_write) begin
        chk("addr_aligned", W'(pmem_address[4:0]), W'(0));
        if (!req_prev) begin
          req_addr  = pmem_address;
          req_wdata = pmem_wdata;
        end else begin
          chk("addr_held", W'(pmem_address), W'(req_addr));
          chk("wdata_held", pmem_wdata, req_wdata);
        end
        if (pmem_resp) begin
          t.wr   = pmem_write;
          t.addr = pmem_address;
          t.data = pmem_wdata;
          log_q.push_back(t);
        end
      end
      if (l2_resp) chk("l2_rdata", l2_rdata, rd_data({l2_address[31:5], 5'b0}));
    end
    req_prev = pmem_read | pmem_write;
    @(posedge clk);
    #1;
    l2_resp_seen = saw_l2;
    if (saw_rst) begin
      fifo_a.delete();
    end else begin
      if (do_pop && fifo_a.size() != 0) void'(fifo_a.pop_front());
      if (do_push) fifo_a.push_back(pend.pop_front());
    end
    if (saw_l2) l2_read = 1'b0;
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      mem_cnt   = 0;
    end else if (pmem_read || pmem_write) begin
      mem_cnt++;
      if (mem_cnt >= lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rd_data(pmem_address);
      end
    end else begin
      mem_cnt = 0;
    end
    drive_ewb();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    l2_read    = 1'b0;
    l2_address = 32'h0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    pend.delete();
    drive_ewb();
    tick();
    tick();
    rst = 1'b0;
    log_q.delete();
    req_prev = 1'b0;
    mem_cnt  = 0;
    #1;
    chk("rst_pmem_read", W'(pmem_read), W'(0));
    chk("rst_pmem_write", W'(pmem_write), W'(0));
    chk("rst_pmem_address", W'(pmem_address), W'(0));
    chk("rst_ewb_yumi", W'(ewb_yumi), W'(0));
    chk("rst_l2_resp", W'(l2_resp), W'(0));
    chk("rst_shadow_count", W'(dut.u_tracker.count), W'(0));
  endtask

  task automatic run_until_idle(input int n_exp, input int budget);
    int cyc;
    cyc = 0;
    while (cyc < budget && !(log_q.size() >= n_exp && !pmem_read && !pmem_write && !l2_read)) begin
      tick();
      cyc++;
    end
    if (cyc >= budget) $display("FAIL timeout: %0d transactions seen, %0d required", log_q.size(), n_exp);
    repeat (8) tick();
  endtask

  task automatic chk_txn(input string name, input int idx, input bit wr, input logic [31:0] addr);
    if (idx < log_q.size()) begin
      chk({name, "_kind"}, W'(log_q[idx].wr), W'(wr));
      chk({name, "_addr"}, W'(log_q[idx].addr), W'(addr));
      if (wr) chk({name, "_wdata"}, log_q[idx].data, ev_data(addr));
    end
  endtask

  vec_t vecs[8];

  initial begin
    n_cmp = 0;
    n_err = 0;
    lat   = 3;
    // lat, n_ev, evictions, rd_en, rd_dly, rd_addr, n_exp, exp_wr, exp_addr
    vecs[0] = '{5, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b1, 0, 32'h0000_1040,
                1, 4'b0000, {32'h0000_1040, 32'h0, 32'h0, 32'h0}};
    vecs[1] = '{2, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b1, 0, 32'h0000_2047,
                1, 4'b0000, {32'h0000_2040, 32'h0, 32'h0, 32'h0}};
    vecs[2] = '{3, 2, {32'h100, 32'h200, 32'h0, 32'h0}, 1'b0, 0, 32'h0,
                2, 4'b1100, {32'h100, 32'h200, 32'h0, 32'h0}};
    vecs[3] = '{3, 1, {32'h300, 32'h0, 32'h0, 32'h0}, 1'b1, 1, 32'h400,
                2, 4'b0100, {32'h400, 32'h300, 32'h0, 32'h0}};
    vecs[4] = '{3, 2, {32'h500, 32'h520, 32'h0, 32'h0}, 1'b1, 2, 32'h520,
                3, 4'b1100, {32'h500, 32'h520, 32'h520, 32'h0}};
    vecs[5] = '{3, 2, {32'h500, 32'h520, 32'h0, 32'h0}, 1'b1, 1, 32'h52C,
                3, 4'b1100, {32'h500, 32'h520, 32'h520, 32'h0}};
    vecs[6] = '{3, 2, {32'h500, 32'h520, 32'h0, 32'h0}, 1'b1, 2, 32'h500,
                3, 4'b1010, {32'h500, 32'h500, 32'h520, 32'h0}};
    vecs[7] = '{3, 1, {32'h600, 32'h0, 32'h0, 32'h0}, 1'b1, 0, 32'h600,
                2, 4'b1000, {32'h600, 32'h600, 32'h0, 32'h0}};

    for (int v = 0; v < 8; v++) begin
      int cyc;
      do_reset();
      lat = vecs[v].lat;
      for (int i = 0; i < vecs[v].n_ev; i++) pend.push_back(vecs[v].ev[i]);
      drive_ewb();
      cyc = 0;
      while (cyc < 300) begin
        if (vecs[v].rd_en && cyc == vecs[v].rd_dly) begin
          l2_read    = 1'b1;
          l2_address = vecs[v].rd_addr;
        end
        tick();
        cyc++;
        if (cyc > vecs[v].rd_dly && log_q.size() >= vecs[v].n_exp &&
            !pmem_read && !pmem_write && !l2_read) break;
      end
      repeat (8) tick();
      chk($sformatf("vec%0d_txn_count", v), W'(log_q.size()), W'(vecs[v].n_exp));
      for (int i = 0; i < vecs[v].n_exp; i++)
        chk_txn($sformatf("vec%0d_t%0d", v, i), i, vecs[v].exp_wr[i], vecs[v].exp_addr[i]);
      chk($sformatf("vec%0d_shadow_empty", v), W'(dut.u_tracker.count), W'(0));
    end

    // Full EWB with a stalled eviction: unblock it with one write before the next read.
    do_reset();
    lat        = 10;
    l2_read    = 1'b1;
    l2_address = 32'h800;
    for (int i = 0; i < 20 && !pmem_read; i++) tick();
    chk("stall_read_started", W'(pmem_read), W'(1));
    pend.push_back(32'h900);
    pend.push_back(32'h920);
    pend.push_back(32'h940);
    pend.push_back(32'h960);
    pend.push_back(32'h980);
    drive_ewb();
    l2_resp_seen = 1'b0;
    for (int i = 0; i < 40 && !l2_resp_seen; i++) tick();
    chk("stall_fifo_full", W'(fifo_a.size()), W'(4));
    chk("stall_evict_blocked", W'(evict_valid & ~evict_ready), W'(1));
    l2_read    = 1'b1;
    l2_address = 32'hA00;
    run_until_idle(7, 300);
    chk("stall_txn_count", W'(log_q.size()), W'(7));
    chk_txn("stall_t0", 0, 1'b0, 32'h800);
    chk_txn("stall_t1", 1, 1'b1, 32'h900);
    chk_txn("stall_t2", 2, 1'b0, 32'hA00);
    chk_txn("stall_t3", 3, 1'b1, 32'h920);
    chk_txn("stall_t6", 6, 1'b1, 32'h980);
    chk("stall_pend_empty", W'(pend.size()), W'(0));

    // Reset in the middle of a write aborts it; a late pmem_resp must not pop.
    do_reset();
    lat = 20;
    pend.push_back(32'h700);
    pend.push_back(32'h720);
    drive_ewb();
    for (int i = 0; i < 20 && !pmem_write; i++) tick();
    chk("rstw_write_started", W'(pmem_write), W'(1));
    chk("rstw_write_addr", W'(pmem_address), W'(32'h700));
    repeat (2) tick();
    rst = 1'b1;
    pend.delete();
    drive_ewb();
    tick();
    rst        = 1'b0;
    pmem_resp  = 1'b1;
    pmem_rdata = rd_data(32'h700);
    #1;
    chk("rstw_pmem_write", W'(pmem_write), W'(0));
    chk("rstw_pmem_read", W'(pmem_read), W'(0));
    chk("rstw_ewb_yumi", W'(ewb_yumi), W'(0));
    chk("rstw_l2_resp", W'(l2_resp), W'(0));
    chk("rstw_shadow_count", W'(dut.u_tracker.count), W'(0));
    repeat (6) tick();
    chk("rstw_no_txn", W'(log_q.size()), W'(0));
    chk("rstw_still_idle", W'(pmem_read | pmem_write), W'(0));
    chk("rstw_shadow_after", W'(dut.u_tracker.count), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
